data_memory_sized: RTL and testbench

Parametrised, byte-addressable data memory for the SigmaCore load/store path. It replaces the word-only data memory with RV32I-sized accesses (LB/LH/LW/LBU/LHU, SB/SH/SW), per-byte lane writes and sign/zero extension. It also adds a configurable read pipeline with a valid strobe, and misalignment/out-of-range fault reporting. It sits between the execute stage's address/store-data outputs and the writeback mux.

---
 rtl/data_memory_sized.sv | 190 +++++++++++++++++++
 tb/tb_data_memory_sized.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressable RV32I data memory with sized loads/stores,
// a 1- or 2-stage read pipeline and response-aligned fault flags.
module data_memory_sized #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_in,
  input  logic [31:0] write_data_in,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [2:0]  funct3_in,
  output logic [31:0] read_data_out,
  output logic        read_valid_out,
  output logic        misaligned_out,
  output logic        out_of_range_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [1:0]    off;
  logic [29:0]   word_off;
  logic [AW-1:0] idx;
  logic          is_b;
  logic          is_h;
  logic          is_w;
  logic          is_bu;
  logic          is_hu;
  logic          legal;
  logic          mis;
  logic          oor;
  logic          req;
  logic          do_write;
  logic [3:0]    be;
  logic [31:0]   wshift;
  logic [31:0]   rd_word;

  logic [31:0]   rd_q;
  logic          vld_q;
  logic          mis_q;
  logic          oor_q;

  function automatic logic [31:0] extend(
    input logic [31:0] w,
    input logic [1:0]  o,
    input logic [2:0]  f3
  );
    logic [31:0] s;
    logic [31:0] r;
    s = w >> {o, 3'b000};
    r = 32'h0;
    unique case (f3)
      F_B:  r = {{24{s[7]}}, s[7:0]};
      F_H:  r = {{16{s[15]}}, s[15:0]};
      F_W:  r = s;
      F_BU: r = {24'h0, s[7:0]};
      F_HU: r = {16'h0, s[15:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  assign off      = addr_in[1:0];
  assign word_off = addr_in[31:2] - BASE_ADDR[31:2];
  assign idx      = word_off[AW-1:0];
  assign req      = read_enable | write_enable;

  always_comb begin
    is_b  = (funct3_in == F_B);
    is_h  = (funct3_in == F_H);
    is_w  = (funct3_in == F_W);
    is_bu = (funct3_in == F_BU);
    is_hu = (funct3_in == F_HU);
    // unsigned codes have no meaning for a store
    legal = is_b | is_h | is_w
          | (~write_enable & (is_bu | is_hu));
    mis   = ~legal
          | ((is_h | is_hu) & off[0])
          | (is_w & (off != 2'd0));
    oor   = (addr_in < BASE_ADDR)
          | (word_off >= DEPTH_W);
  end

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      is_b:    be = 4'b0001 << off;
      is_h:    be = 4'b0011 << off;
      is_w:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wshift   = write_data_in << {off, 3'b000};
  assign do_write = write_enable & ~mis & ~oor;
  assign rd_word  = mem[idx];

  always_ff @(posedge clk) begin
    if (rst_n && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        s1_vld;
      logic        s1_req;
      logic        s1_mis;
      logic        s1_oor;
      logic [31:0] s1_word;
      logic [1:0]  s1_off;
      logic [2:0]  s1_f3;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld  <= 1'b0;
          s1_req  <= 1'b0;
          s1_mis  <= 1'b0;
          s1_oor  <= 1'b0;
          s1_word <= 32'h0;
          s1_off  <= 2'd0;
          s1_f3   <= 3'd0;
        end else begin
          s1_vld <= read_enable;
          s1_req <= req;
          s1_mis <= mis;
          s1_oor <= oor;
          if (read_enable) begin
            s1_word <= rd_word;
            s1_off  <= off;
            s1_f3   <= funct3_in;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q  <= 32'h0;
          vld_q <= 1'b0;
          mis_q <= 1'b0;
          oor_q <= 1'b0;
        end else begin
          vld_q <= s1_vld;
          mis_q <= s1_req & s1_mis;
          oor_q <= s1_req & s1_oor & ~s1_mis;
          if (s1_vld) begin
            rd_q <= (s1_mis | s1_oor) ? 32'h0
                  : extend(s1_word, s1_off, s1_f3);
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q  <= 32'h0;
          vld_q <= 1'b0;
          mis_q <= 1'b0;
          oor_q <= 1'b0;
        end else begin
          vld_q <= read_enable;
          mis_q <= req & mis;
          oor_q <= req & oor & ~mis;
          if (read_enable) begin
            rd_q <= (mis | oor) ? 32'h0
                  : extend(rd_word, off, funct3_in);
          end
        end
      end
    end
  endgenerate

  assign read_data_out    = rd_q;
  assign read_valid_out   = vld_q;
  assign misaligned_out   = mis_q;
  assign out_of_range_out = oor_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: one instance per read
// latency, both driven by the same request stream.
module tb_data_memory_sized;

  logic        clk_tb;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [2:0]  f3;

  logic [31:0] rd1, rd2;
  logic        v1, v2, m1, m2, o1, o2;

  int checks = 0;
  int errors = 0;

  data_memory_sized #(.READ_LATENCY(1)) dut1 (
    .clk(clk_tb), .rst_n(rst_n), .addr_in(addr),
    .write_data_in(wdata), .write_enable(we),
    .read_enable(re), .funct3_in(f3),
    .read_data_out(rd1), .read_valid_out(v1),
    .misaligned_out(m1), .out_of_range_out(o1)
  );

  data_memory_sized #(.READ_LATENCY(2)) dut2 (
    .clk(clk_tb), .rst_n(rst_n), .addr_in(addr),
    .write_data_in(wdata), .write_enable(we),
    .read_enable(re), .funct3_in(f3),
    .read_data_out(rd2), .read_valid_out(v2),
    .misaligned_out(m2), .out_of_range_out(o2)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One request, then both responses checked at their own latency.
  task automatic access(input string tag,
                        input logic w, input logic r,
                        input logic [2:0] fc,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [31:0] exp_d,
                        input logic e_mis, input logic e_oor);
    @(negedge clk_tb);
    we = w; re = r; f3 = fc; addr = a; wdata = d;
    @(posedge clk_tb);
    #1;
    we = 1'b0; re = 1'b0;
    chk({tag, " l1 valid"}, 32'(v1), 32'(r));
    if (r) chk({tag, " l1 data"}, rd1, exp_d);
    chk({tag, " l1 mis"}, 32'(m1), 32'(e_mis));
    chk({tag, " l1 oor"}, 32'(o1), 32'(e_oor));
    chk({tag, " l2 early"}, {29'h0, v2, m2, o2}, 32'h0);
    @(posedge clk_tb);
    #1;
    chk({tag, " l2 valid"}, 32'(v2), 32'(r));
    if (r) chk({tag, " l2 data"}, rd2, exp_d);
    chk({tag, " l2 mis"}, 32'(m2), 32'(e_mis));
    chk({tag, " l2 oor"}, 32'(o2), 32'(e_oor));
    chk({tag, " l1 idle"}, {29'h0, v1, m1, o1}, 32'h0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " l1 data"}, rd1, 32'h0);
    chk({tag, " l2 data"}, rd2, 32'h0);
    chk({tag, " flags"}, {26'h0, v1, m1, o1, v2, m2, o2}, 32'h0);
  endtask

  logic [31:0] bb_addr [3];
  logic [31:0] bb_exp  [3];

  initial begin
    rst_n = 1'b1;
    we = 1'b0; re = 1'b0; f3 = 3'b010;
    addr = 32'h0; wdata = 32'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk_tb);
    #1 all_zero("reset");
    @(negedge clk_tb);
    rst_n = 1'b1;

    access("sw cafebabe", 1, 0, 3'b010, 32'h100, 32'hCAFEBABE, 0, 0, 0);
    access("lw 100",      0, 1, 3'b010, 32'h100, 0, 32'hCAFEBABE, 0, 0);
    access("sb 5a",       1, 0, 3'b000, 32'h101, 32'hFFFF005A, 0, 0, 0);
    access("lw merged",   0, 1, 3'b010, 32'h100, 0, 32'hCAFE5ABE, 0, 0);
    access("lb 101",      0, 1, 3'b000, 32'h101, 0, 32'h0000005A, 0, 0);
    access("lb 103",      0, 1, 3'b000, 32'h103, 0, 32'hFFFFFFCA, 0, 0);
    access("lbu 103",     0, 1, 3'b100, 32'h103, 0, 32'h000000CA, 0, 0);
    access("lh 102",      0, 1, 3'b001, 32'h102, 0, 32'hFFFFCAFE, 0, 0);
    access("lhu 102",     0, 1, 3'b101, 32'h102, 0, 32'h0000CAFE, 0, 0);
    access("sh 0x8001",   1, 0, 3'b001, 32'h102, 32'h12348001, 0, 0, 0);
    access("lw after sh", 0, 1, 3'b010, 32'h100, 0, 32'h80015ABE, 0, 0);
    access("sw restore",  1, 0, 3'b010, 32'h100, 32'hCAFE5ABE, 0, 0, 0);

    access("sw 200",      1, 0, 3'b010, 32'h200, 32'hAAAA5555, 0, 0, 0);
    access("sw mis 202",  1, 0, 3'b010, 32'h202, 32'h12345678, 0, 1, 0);
    access("lw 200 kept", 0, 1, 3'b010, 32'h200, 0, 32'hAAAA5555, 0, 0);
    access("lh mis 101",  0, 1, 3'b001, 32'h101, 0, 32'h0, 1, 0);
    access("lw f3 011",   0, 1, 3'b011, 32'h100, 0, 32'h0, 1, 0);

    access("sw word0",    1, 0, 3'b010, 32'h0, 32'h11111111, 0, 0, 0);
    access("lw oor",      0, 1, 3'b010, 32'h1000, 0, 32'h0, 0, 1);
    access("sw oor",      1, 0, 3'b010, 32'h1000, 32'h99, 0, 0, 1);
    access("lw word0",    0, 1, 3'b010, 32'h0, 0, 32'h11111111, 0, 0);
    access("lw mis+oor",  0, 1, 3'b010, 32'h1002, 0, 32'h0, 1, 0);
    access("sbu illegal", 1, 0, 3'b100, 32'h0, 32'hFF, 0, 1, 0);
    access("lw word0 b",  0, 1, 3'b010, 32'h0, 0, 32'h11111111, 0, 0);

    access("rw same",     1, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'hCAFE5ABE, 0, 0);
    access("lw new",      0, 1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0);

    bb_addr[0] = 32'h100; bb_exp[0] = 32'hDEADBEEF;
    bb_addr[1] = 32'h0;   bb_exp[1] = 32'h11111111;
    bb_addr[2] = 32'h200; bb_exp[2] = 32'hAAAA5555;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_tb);
      re = (k < 3);
      f3 = 3'b010;
      if (k < 3) addr = bb_addr[k];
      @(posedge clk_tb);
      #1;
      if (k < 3) begin
        chk("b2b l1 valid", 32'(v1), 32'h1);
        chk("b2b l1 data", rd1, bb_exp[k]);
      end else begin
        chk("b2b l1 idle", 32'(v1), 32'h0);
      end
      if (k > 0) begin
        chk("b2b l2 valid", 32'(v2), 32'h1);
        chk("b2b l2 data", rd2, bb_exp[k-1]);
      end else begin
        chk("b2b l2 early", 32'(v2), 32'h0);
      end
    end
    re = 1'b0;

    // LW in flight in the 2-stage pipe when reset hits
    @(negedge clk_tb);
    re = 1'b1; f3 = 3'b010; addr = 32'h100;
    @(posedge clk_tb);
    #1;
    re = 1'b0;
    chk("rst l1 resp", rd1, 32'hDEADBEEF);
    @(negedge clk_tb);
    rst_n = 1'b0;
    #1 all_zero("in reset");
    we = 1'b1; f3 = 3'b010; addr = 32'h100; wdata = 32'h0;
    @(posedge clk_tb);
    #1 all_zero("reset store");
    @(negedge clk_tb);
    we = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk_tb);
      #1 all_zero("post reset");
    end
    access("lw after rst", 0, 1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
